bram_req_adapter: RTL and testbench

- Front-end stage that sits directly upstream of the single-port byte-enable BRAM wrapper.
- Converts a valid/ready request stream (CPU/vector LSU side) into the BRAM's fixed-latency enable/byte-write interface.
- Tracks in-flight reads and buffers read data in a response FIFO, so the consumer may stall without losing data.
- Guarantees one in-order response per accepted request.

---
 rtl/bram_req_adapter_pkg.sv | 33 +++
 rtl/bram_req_adapter_if.sv | 54 +++++
 rtl/bram_req_adapter_rsp_fifo.sv | 59 +++++
 rtl/bram_req_adapter.sv | 154 +++++++++++++++
 tb/tb_bram_req_adapter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_req_adapter_pkg.sv
// ============================================================================
// Module   : bram_req_adapter_pkg
// Purpose  : Shared types and constants for the BRAM request adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_req_adapter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BYTE_WIDTH_DEF = 8;
  localparam int RAM_DEPTH_DEF  = 1024;

  localparam int NB = (DATA_WIDTH_DEF + BYTE_WIDTH_DEF - 1) / BYTE_WIDTH_DEF;
  localparam int AW = $clog2(RAM_DEPTH_DEF);

  typedef struct packed {
    logic valid;
    logic we;
  } inflight_t;

  typedef struct packed {
    logic                      we;
    logic [DATA_WIDTH_DEF-1:0] rdata;
  } rsp_t;

  function automatic int nb_of(input int data_width, input int byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_req_adapter_if.sv
// ============================================================================
// Module   : bram_req_adapter_if
// Purpose  : Request, response and BRAM-side signals of the request adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_req_adapter_if
  import bram_req_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RAM_DEPTH  = 1024
);

  localparam int C_NB = nb_of(DATA_WIDTH, BYTE_WIDTH);
  localparam int C_AW = $clog2(RAM_DEPTH);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [C_AW-1:0]       req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [C_NB-1:0]       req_be_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_we_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;

  logic                  mem_re_o;
  logic [C_NB-1:0]       mem_we_o;
  logic [C_AW-1:0]       mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_regcea_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o,
    output mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_regcea_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o,
    input  mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_regcea_o
  );

endinterface

`default_nettype wire

// File: rtl/bram_req_adapter_rsp_fifo.sv
// ============================================================================
// Module   : bram_rsp_fifo
// Purpose  : Registered synchronous response FIFO with occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 33
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_ni,
  input  wire logic                       i_push,
  input  wire logic [WIDTH-1:0]           i_data,
  input  wire logic                       i_pop,
  output logic      [WIDTH-1:0]           o_data,
  output logic      [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int C_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_PW-1:0]  r_wr_ptr;
  logic [C_PW-1:0]  r_rd_ptr;
  logic [C_CW-1:0]  r_count;

  function automatic logic [C_PW-1:0] ptr_inc(input logic [C_PW-1:0] ptr);
    return (ptr == C_PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bram_req_adapter.sv
// ============================================================================
// Module   : bram_req_adapter
// Purpose  : Valid/ready request stream to fixed-latency BRAM port adapter
//            with credit-based response buffering.
// Options  : BRAM_REQ_ADAPTER_PERF_CNT_EN adds read/write/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_req_adapter
  import bram_req_adapter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 3
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  bram_req_adapter_if.slave bus
`ifdef BRAM_REQ_ADAPTER_PERF_CNT_EN
  ,
  output logic [31:0]       perf_rd_o,
  output logic [31:0]       perf_wr_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int C_AW = $clog2(RAM_DEPTH);
  localparam int C_CW = $clog2(FIFO_DEPTH + 1);
  localparam int C_RW = DATA_WIDTH + 1;

  if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
    $error("bram_req_adapter: READ_LATENCY must be 1 or 2");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("bram_req_adapter: FIFO_DEPTH must be at least 1");
  end

  logic                  w_fire;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_rsp_valid;
  logic [C_RW-1:0]       w_push_data;
  logic [C_RW-1:0]       w_head;
  logic [C_CW-1:0]       w_fifo_count;
  logic [C_CW-1:0]       w_credit_nxt;

  logic [C_CW-1:0]       r_credit;
  logic                  r_ready;
  logic [C_AW-1:0]       r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  inflight_t             r_pipe [READ_LATENCY];

  assign w_fire          = bus.req_valid_i & r_ready;
  assign bus.req_ready_o = r_ready;

  // Credits cover every request that may still land in the FIFO, so a push
  // can never overflow it; ready is registered to keep it off any input path.
  always_comb begin
    w_credit_nxt = r_credit;
    case ({w_fire, w_pop})
      2'b10:   w_credit_nxt = r_credit + 1'b1;
      2'b01:   w_credit_nxt = r_credit - 1'b1;
      default: w_credit_nxt = r_credit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_credit <= '0;
      r_ready  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_credit <= w_credit_nxt;
      r_ready  <= (w_credit_nxt < C_CW'(FIFO_DEPTH));
      if (w_fire) begin
        r_addr  <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
      end
    end
  end

  assign bus.mem_re_o    = w_fire;
  assign bus.mem_we_o    = (w_fire & bus.req_we_i) ? bus.req_be_i : '0;
  assign bus.mem_addr_o  = w_fire ? bus.req_addr_i  : r_addr;
  assign bus.mem_wdata_o = w_fire ? bus.req_wdata_i : r_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_fire, we: w_fire & bus.req_we_i};
      for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  if (READ_LATENCY == 2) begin : g_regcea_pipe
    assign bus.mem_regcea_o = r_pipe[0].valid;
  end else begin : g_regcea_tied
    assign bus.mem_regcea_o = 1'b1;
  end

  assign w_push      = r_pipe[READ_LATENCY-1].valid;
  assign w_push_data = r_pipe[READ_LATENCY-1].we ? {1'b1, {DATA_WIDTH{1'b0}}}
                                                 : {1'b0, bus.mem_rdata_i};

  bram_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (C_RW)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign w_rsp_valid     = (w_fifo_count != '0);
  assign w_pop           = w_rsp_valid & bus.rsp_ready_i;
  assign bus.rsp_valid_o = w_rsp_valid;
  assign bus.rsp_we_o    = w_head[DATA_WIDTH];
  assign bus.rsp_rdata_o = w_head[DATA_WIDTH-1:0];

`ifdef BRAM_REQ_ADAPTER_PERF_CNT_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fire && !bus.req_we_i && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_fire &&  bus.req_we_i && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (bus.req_valid_i && !r_ready && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign perf_rd_o    = r_rd_cnt;
  assign perf_wr_o    = r_wr_cnt;
  assign perf_stall_o = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_req_adapter.sv
// ============================================================================
// Module   : tb_bram_req_adapter
// Purpose  : Scoreboard bench for bram_req_adapter with a behavioural BRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_req_adapter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_req_adapter_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(1024)) bus ();

`ifdef BRAM_REQ_ADAPTER_PERF_CNT_EN
  logic [31:0] perf_rd, perf_wr, perf_stall;
`endif

  bram_req_adapter #(
    .DATA_WIDTH   (32),
    .BYTE_WIDTH   (8),
    .RAM_DEPTH    (1024),
    .READ_LATENCY (2),
    .FIFO_DEPTH   (3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef BRAM_REQ_ADAPTER_PERF_CNT_EN
    ,
    .perf_rd_o    (perf_rd),
    .perf_wr_o    (perf_wr),
    .perf_stall_o (perf_stall)
`endif
  );

  // Two-cycle BRAM: array read then output register gated by regcea.
  logic [31:0] ram [1024];
  logic [31:0] bram_q1, bram_q2;
  always @(posedge clk) begin
    if (bus.mem_re_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we_o[b]) ram[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
      bram_q1 <= ram[bus.mem_addr_o];
    end
    if (bus.mem_regcea_o) bram_q2 <= bram_q1;
  end
  assign bus.mem_rdata_i = bram_q2;

  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] shadow [1024];
  logic [32:0] exp_q [$];
  int          acc_cyc_q [$];
  int          pop_cyc_q [$];
  logic [32:0] mon_got, mon_exp, mon_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
      mon_got  = {bus.rsp_we_o, bus.rsp_rdata_o};
      mon_last = mon_got;
      pop_cyc_q.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got %h, required no response", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp)
          $display("FAIL rsp_data: got %h, required %h", mon_got, mon_exp);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_be_i    = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic send(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output int waited);
    waited          = 0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_be_i    = be;
    while (!bus.req_ready_o && waited < 50) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!bus.req_ready_o) begin
      $display("FAIL send_accept: got ready=%0b after %0d cycles, required 1", bus.req_ready_o, waited);
    end else begin
      n_pass++;
      acc_cyc_q.push_back(cyc);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[addr][b*8 +: 8] = wdata[b*8 +: 8];
        exp_q.push_back({1'b1, 32'h0});
      end else begin
        exp_q.push_back({1'b0, shadow[addr]});
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.rsp_ready_i = 1'b1;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    idle();
    tick();
    tick();
    n_checks++;
    if (bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0)
      $display("FAIL reset_handshake: got ready=%b rsp_valid=%b, required 0 0", bus.req_ready_o, bus.rsp_valid_o);
    else n_pass++;
    n_checks++;
    if (bus.mem_re_o !== 1'b0 || bus.mem_we_o !== 4'h0 || bus.mem_regcea_o !== 1'b0)
      $display("FAIL reset_mem_ctrl: got re=%b we=%h regcea=%b, required 0 0 0", bus.mem_re_o, bus.mem_we_o, bus.mem_regcea_o);
    else n_pass++;
    n_checks++;
    if (bus.mem_addr_o !== 10'h0 || bus.mem_wdata_o !== 32'h0)
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h, required 0 0", bus.mem_addr_o, bus.mem_wdata_o);
    else n_pass++;
    n_checks++;
    if (bus.rsp_we_o !== 1'b0 || bus.rsp_rdata_o !== 32'h0)
      $display("FAIL reset_rsp: got we=%b rdata=%h, required 0 0", bus.rsp_we_o, bus.rsp_rdata_o);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.req_ready_o !== 1'b1)
      $display("FAIL reset_ready: got %b, required 1", bus.req_ready_o);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int w;
    acc_cyc_q.delete();
    pop_cyc_q.delete();
    send(1'b1, 10'h10, 32'hDEADBEEF, 4'hF, w);
    send(1'b0, 10'h10, 32'h0, 4'h0, w);
    idle();
    wait_drain();
    n_checks++;
    if (mon_last !== {1'b0, 32'hDEADBEEF})
      $display("FAIL wr_rd_data: got %h, required %h", mon_last, {1'b0, 32'hDEADBEEF});
    else n_pass++;
    n_checks++;
    if (pop_cyc_q.size() != 2 || acc_cyc_q.size() != 2 ||
        pop_cyc_q[0] - acc_cyc_q[0] != 3 || pop_cyc_q[1] - acc_cyc_q[1] != 3)
      $display("FAIL wr_rd_latency: got %0d responses, read latency %0d, required 2 responses latency 3",
               pop_cyc_q.size(), (pop_cyc_q.size() > 1) ? pop_cyc_q[1] - acc_cyc_q[1] : -1);
    else n_pass++;
  endtask

  task automatic test_byte_enable();
    int w;
    send(1'b1, 10'd5, 32'h11223344, 4'hF, w);
    send(1'b1, 10'd5, 32'hAABBCCDD, 4'b0101, w);
    send(1'b0, 10'd5, 32'h0, 4'h0, w);
    idle();
    wait_drain();
    n_checks++;
    if (mon_last !== {1'b0, 32'h11BB33DD})
      $display("FAIL byte_enable: got %h, required %h", mon_last, {1'b0, 32'h11BB33DD});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 8; i++) send(1'b1, 10'(i), 32'h10203040 + i * 32'h01010101, 4'hF, w);
    idle();
    wait_drain();
    acc_cyc_q.delete();
    pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) send(1'b0, 10'(i), 32'h0, 4'h0, w);
    idle();
    wait_drain();
    n_checks++;
    if (pop_cyc_q.size() != 8 || exp_q.size() != 0)
      $display("FAIL b2b_count: got %0d responses, required 8", pop_cyc_q.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < pop_cyc_q.size(); i++) begin
      n_checks++;
      if (pop_cyc_q[i] - acc_cyc_q[i] != 3)
        $display("FAIL b2b_latency: response %0d got %0d cycles, required 3", i, pop_cyc_q[i] - acc_cyc_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    int w;
    pop_cyc_q.delete();
    send(1'b0, 10'd1, 32'h0, 4'h0, w);
    send(1'b0, 10'd2, 32'h0, 4'h0, w);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1)
      $display("FAIL midreset_state: got rsp_valid=%b ready=%b, required 0 1", bus.rsp_valid_o, bus.req_ready_o);
    else n_pass++;
    repeat (8) tick();
    n_checks++;
    if (pop_cyc_q.size() != 0)
      $display("FAIL midreset_stale: got %0d responses, required 0", pop_cyc_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc    = 0;
    int stalls = 0;
    int n      = 0;
    bus.rsp_ready_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_be_i    = '0;
    bus.req_addr_i  = 10'd0;
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.req_valid_i) begin
        if (bus.req_ready_o) begin
          exp_q.push_back({1'b0, shadow[acc]});
          acc++;
        end else stalls++;
      end
      tick();
      if (acc < 6) bus.req_addr_i = 10'(acc); else bus.req_valid_i = 1'b0;
    end
    n_checks++;
    if (acc != 3) $display("FAIL stall_accepted: got %0d, required 3", acc);
    else n_pass++;
    n_checks++;
    if (bus.req_ready_o !== 1'b0) $display("FAIL stall_ready: got %b, required 0", bus.req_ready_o);
    else n_pass++;
    bus.rsp_ready_i = 1'b1;
    while ((acc < 6 || exp_q.size() != 0) && n < 60) begin
      if (bus.req_valid_i) begin
        if (bus.req_ready_o) begin
          exp_q.push_back({1'b0, shadow[acc]});
          acc++;
        end else stalls++;
      end
      tick();
      n++;
      if (acc < 6) bus.req_addr_i = 10'(acc); else bus.req_valid_i = 1'b0;
    end
    tick();
    n_checks++;
    if (acc != 6 || exp_q.size() != 0)
      $display("FAIL stall_drain: got accepted=%0d pending=%0d, required 6 0", acc, exp_q.size());
    else n_pass++;
`ifdef BRAM_REQ_ADAPTER_PERF_CNT_EN
    n_checks++;
    if (perf_rd !== 32'd6 || perf_wr !== 32'd0 || perf_stall !== 32'(stalls))
      $display("FAIL perf_counters: got rd=%0d wr=%0d stall=%0d, required 6 0 %0d", perf_rd, perf_wr, perf_stall, stalls);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_reset_midflight();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
